// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the shift-free add-loop multiplier controller.
// Holds the FSM state encoding and the operand/product widths.
package mul_ctrl_pkg;

    localparam int OPERAND_W = 8;
    localparam int PRODUCT_W = 2 * OPERAND_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        LOOP = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// Control/status bundle between mul_ctrl (master) and its datapath (slave).
// The abort line exists only when MUL_CTRL_ABORT_EN is defined.
interface mul_ctrl_if;

    logic start;
    logic data_valid;
    logic zero;
    logic ldA;
    logic ldB;
    logic ldP;
    logic clrP;
    logic decB;
    logic add;
    logic busy;
    logic done;

`ifdef MUL_CTRL_ABORT_EN
    logic abort;

    modport master (
        input  start, data_valid, zero, abort,
        output ldA, ldB, ldP, clrP, decB, add, busy, done
    );

    modport slave (
        output start, data_valid, zero, abort,
        input  ldA, ldB, ldP, clrP, decB, add, busy, done
    );
`else
    modport master (
        input  start, data_valid, zero,
        output ldA, ldB, ldP, clrP, decB, add, busy, done
    );

    modport slave (
        output start, data_valid, zero,
        input  ldA, ldB, ldP, clrP, decB, add, busy, done
    );
`endif

endinterface

// File: rtl/mul_ctrl.sv
// Repeated-addition multiplier controller: loads A, loads B, adds A into P until B hits zero.
// Optional cancel input enabled by defining MUL_CTRL_ABORT_EN.
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input logic       clk,
    input logic       reset,
    mul_ctrl_if.master bus
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each load/loop strobe is tied to exactly one state, so ldB/decB and clrP/add never overlap.
    always_comb begin
        state_d  = state_q;
        bus.ldA  = 1'b0;
        bus.ldB  = 1'b0;
        bus.ldP  = 1'b0;
        bus.clrP = 1'b0;
        bus.decB = 1'b0;
        bus.add  = 1'b0;
        bus.done = 1'b0;
        bus.busy = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LDA;
                end
            end
            LDA: begin
                bus.ldA = bus.data_valid;
                if (bus.data_valid) begin
                    state_d = LDB;
                end
            end
            LDB: begin
                bus.ldB  = bus.data_valid;
                bus.clrP = bus.data_valid;
                if (bus.data_valid) begin
                    state_d = LOOP;
                end
            end
            LOOP: begin
                bus.add  = ~bus.zero;
                bus.decB = ~bus.zero;
                if (bus.zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef MUL_CTRL_ABORT_EN
        // Cancel wins over every other transition; busy stays high until IDLE is reached.
        if (bus.abort && (state_q != IDLE)) begin
            bus.ldA  = 1'b0;
            bus.ldB  = 1'b0;
            bus.clrP = 1'b0;
            bus.decB = 1'b0;
            bus.add  = 1'b0;
            bus.done = 1'b0;
            state_d  = IDLE;
        end
`endif
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl with a behavioural datapath and randomized operands.
// Abort scenario is exercised when MUL_CTRL_ABORT_EN is defined.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    typedef struct {
        int product;
        int adds;
        int latency;
        int startEdge;
    } expect_t;

    logic clk;
    logic reset;
    logic [OPERAND_W-1:0] dataIn;
    logic [OPERAND_W-1:0] regA;
    logic [OPERAND_W-1:0] regB;
    logic [PRODUCT_W-1:0] product;

    int testsRun;
    int testsFailed;
    int edgeCount;
    int addCount;
    expect_t sbQ[$];

    mul_ctrl_if bus ();

    mul_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Behavioural datapath driven by the controller strobes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            regA    <= '0;
            regB    <= '0;
            product <= '0;
        end else begin
            if (bus.ldA)  regA <= dataIn;
            if (bus.ldB)  regB <= dataIn;
            if (bus.decB) regB <= regB - 1'b1;
            if (bus.clrP) product <= '0;
            if (bus.add)  product <= product + PRODUCT_W'(regA);
        end
    end

    assign bus.zero = (regB == '0);

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: counts add pulses per operation and scores every done pulse.
    always @(negedge clk) begin
        expect_t exp;
        if (reset || !bus.busy) begin
            addCount = 0;
        end else begin
            if (bus.add) addCount++;
            checkOutput("strobeConflict",
                        {29'd0, bus.ldP, bus.ldB & bus.decB, bus.clrP & bus.add}, 0);
            if (bus.done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedDone", 1, 0);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("product", int'(product), exp.product);
                    checkOutput("addPulses", addCount, exp.adds);
                    checkOutput("latency", edgeCount - exp.startEdge + 1, exp.latency);
                end
            end
        end
    end

    task automatic waitIdle();
        int budget = 1000;
        while (bus.busy && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (bus.busy) checkOutput("idleTimeout", 1, 0);
    endtask

    task automatic applyStimulus(input int a, input int b, input int stallA, input int stallB,
                                 input bit poke);
        expect_t exp;
        waitIdle();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        exp.product   = a * b;
        exp.adds      = b;
        exp.latency   = b + 4 + stallA + stallB;
        exp.startEdge = edgeCount;
        sbQ.push_back(exp);
        checkOutput("busyAfterStart", int'(bus.busy), 1);
        repeat (stallA) begin
            bus.data_valid = 1'b0;
            dataIn = OPERAND_W'($urandom);
            @(posedge clk);
            #1;
        end
        bus.data_valid = 1'b1;
        dataIn = OPERAND_W'(a);
        @(posedge clk);
        #1;
        repeat (stallB) begin
            bus.data_valid = 1'b0;
            dataIn = OPERAND_W'($urandom);
            @(posedge clk);
            #1;
        end
        bus.data_valid = 1'b1;
        dataIn = OPERAND_W'(b);
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        if (poke) begin
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int seen;
        testsRun       = 0;
        testsFailed    = 0;
        edgeCount      = 0;
        addCount       = 0;
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        dataIn         = '0;
`ifdef MUL_CTRL_ABORT_EN
        bus.abort      = 1'b0;
`endif
        reset = 1'b1;
        #12;
        checkOutput("resetOutputs", {24'd0, bus.busy, bus.done, bus.ldA, bus.ldB, bus.ldP,
                                     bus.clrP, bus.decB, bus.add}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(7, 5, 0, 0, 1'b0);
        applyStimulus(200, 0, 0, 0, 1'b1);
        applyStimulus(255, 255, 0, 0, 1'b0);
        applyStimulus(3, 4, 3, 2, 1'b1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 30)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the third add of an operation that will never finish.
        applyStimulus(11, 9, 0, 0, 1'b0);
        seen = 0;
        for (int c = 0; c < 50 && seen < 3; c++) begin
            @(negedge clk);
            if (bus.add) seen++;
        end
        checkOutput("thirdAddSeen", seen, 3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midLoopReset", {24'd0, bus.busy, bus.done, bus.ldA, bus.ldB, bus.ldP,
                                     bus.clrP, bus.decB, bus.add}, 0);
        sbQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(2, 2, 0, 0, 1'b0);

`ifdef MUL_CTRL_ABORT_EN
        // Cancel a running loop with a concurrent start that must not be remembered.
        applyStimulus(9, 10, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        checkOutput("abortStrobes", {26'd0, bus.done, bus.ldA, bus.ldB, bus.clrP,
                                     bus.decB, bus.add}, 0);
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        sbQ.delete();
        checkOutput("busyAfterAbort", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        checkOutput("startIgnoredInAbort", int'(bus.busy), 0);
        applyStimulus(6, 7, 0, 0, 1'b0);
`endif

        waitIdle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pendingAtEnd", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
